mc_ctrl_hs: RTL and testbench

- Next-generation multicycle controller FSM for the 16-bit CPU datapath.
- Decodes op/op_ext and drives the datapath mux selects and enables.
- New over the previous controller:
  - memory accesses use a req/rdy handshake, so memory latency is variable;
  - WAIT length is a parameter, and WAIT can end early on a wake input;
  - unknown opcodes trap into a halted state.

---
 rtl/ctrl_defs.sv | 111 +++++++++++
 rtl/cond_eval.sv | 43 ++++
 rtl/mc_ctrl_hs.sv | 221 ++++++++++++++++++++++
 tb/tb_mc_ctrl_hs.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_defs.sv
// Shared encodings for the mc_ctrl_hs multicycle controller: FSM states, opcodes,
// condition codes, datapath mux selects and the bundled control word.
package ctrl_defs;

  localparam int unsigned StateW = 5;

  localparam logic [StateW-1:0] StFetch     = 5'd0;
  localparam logic [StateW-1:0] StDecode    = 5'd1;
  localparam logic [StateW-1:0] StREx       = 5'd2;
  localparam logic [StateW-1:0] StIEx       = 5'd3;
  localparam logic [StateW-1:0] StWrite     = 5'd4;
  localparam logic [StateW-1:0] StLdMem     = 5'd5;
  localparam logic [StateW-1:0] StLdWb      = 5'd6;
  localparam logic [StateW-1:0] StStMem     = 5'd7;
  localparam logic [StateW-1:0] StStiMem    = 5'd8;
  localparam logic [StateW-1:0] StCalcDisp  = 5'd9;
  localparam logic [StateW-1:0] StJump      = 5'd10;
  localparam logic [StateW-1:0] StCalcRlink = 5'd11;
  localparam logic [StateW-1:0] StWrRlink   = 5'd12;
  localparam logic [StateW-1:0] StPcUp      = 5'd13;
  localparam logic [StateW-1:0] StWait      = 5'd14;
  localparam logic [StateW-1:0] StTrap      = 5'b11111;

  localparam logic [3:0] OpRtype   = 4'b0000;
  localparam logic [3:0] OpAndi    = 4'b0001;
  localparam logic [3:0] OpOri     = 4'b0010;
  localparam logic [3:0] OpXori    = 4'b0011;
  localparam logic [3:0] OpSpecial = 4'b0100;
  localparam logic [3:0] OpSti     = 4'b0111;
  localparam logic [3:0] OpShift   = 4'b1000;
  localparam logic [3:0] OpCmpi    = 4'b1011;
  localparam logic [3:0] OpBcond   = 4'b1100;

  localparam logic [3:0] ExtWait  = 4'b0000;
  localparam logic [3:0] ExtLoad  = 4'b0000;
  localparam logic [3:0] ExtStor  = 4'b0100;
  localparam logic [3:0] ExtLsh   = 4'b0100;
  localparam logic [3:0] ExtJal   = 4'b1000;
  localparam logic [3:0] ExtCmp   = 4'b1011;
  localparam logic [3:0] ExtJcond = 4'b1100;

  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondCs = 4'b0010;
  localparam logic [3:0] CondCc = 4'b0011;
  localparam logic [3:0] CondHi = 4'b0100;
  localparam logic [3:0] CondLs = 4'b0101;
  localparam logic [3:0] CondGt = 4'b0110;
  localparam logic [3:0] CondLe = 4'b0111;
  localparam logic [3:0] CondFs = 4'b1000;
  localparam logic [3:0] CondFc = 4'b1001;
  localparam logic [3:0] CondLo = 4'b1010;
  localparam logic [3:0] CondHs = 4'b1011;
  localparam logic [3:0] CondLt = 4'b1100;
  localparam logic [3:0] CondGe = 4'b1101;
  localparam logic [3:0] CondUc = 4'b1110;

  // Flag positions inside PSR.
  localparam int unsigned PsrC = 0;
  localparam int unsigned PsrL = 1;
  localparam int unsigned PsrF = 2;
  localparam int unsigned PsrZ = 3;
  localparam int unsigned PsrN = 4;

  localparam logic [1:0] WdReg      = 2'b00;
  localparam logic [1:0] WdMem      = 2'b10;
  localparam logic [1:0] WdAlu      = 2'b11;
  localparam logic [1:0] AluAReg    = 2'b00;
  localparam logic [1:0] AluAPc     = 2'b01;
  localparam logic [1:0] AluAImm    = 2'b10;
  localparam logic [1:0] AluBReg    = 2'b00;
  localparam logic [1:0] AluBDisp   = 2'b01;
  localparam logic [1:0] AluBOne    = 2'b10;
  localparam logic [1:0] MemAddrReg = 2'b00;
  localparam logic [1:0] MemAddrPc  = 2'b01;
  localparam logic [1:0] MemAddrImm = 2'b10;
  localparam logic [1:0] MemDataReg = 2'b00;
  localparam logic [1:0] MemDataImm = 2'b01;

  typedef struct packed {
    logic       mem_req;
    logic [1:0] wd_s;
    logic [1:0] alua_s;
    logic [1:0] alub_s;
    logic [1:0] mem_s;
    logic [1:0] mem_data_s;
    logic       pc_s;
    logic       pc_en;
    logic       reg_wr_en;
    logic       instr_en;
    logic       alu_out_en;
    logic       mem_reg_en;
    logic       mem_wr_s;
    logic       se_sign;
    logic       psr_en;
    logic       halted;
  } ctrl_out_t;

  function automatic ctrl_out_t ctrl_default();
    ctrl_out_t c;
    c            = '0;
    c.wd_s       = WdReg;
    c.alua_s     = AluAReg;
    c.alub_s     = AluBReg;
    c.mem_s      = MemAddrReg;
    c.mem_data_s = MemDataReg;
    c.se_sign    = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator: decides whether a Bcond/Jcond is taken from the
// condition field and the current PSR flags. Purely combinational.
module cond_eval
  import ctrl_defs::*;
#(
  parameter int unsigned PSR_W = 5
) (
  input  logic [3:0]       branch_cond,
  input  logic [PSR_W-1:0] PSR,
  output logic             taken
);

  logic flag_c, flag_l, flag_f, flag_z, flag_n;

  assign flag_c = PSR[PsrC];
  assign flag_l = PSR[PsrL];
  assign flag_f = PSR[PsrF];
  assign flag_z = PSR[PsrZ];
  assign flag_n = PSR[PsrN];

  always_comb begin
    taken = 1'b0;
    case (branch_cond)
      CondEq:  taken = flag_z;
      CondNe:  taken = !flag_z;
      CondCs:  taken = flag_c;
      CondCc:  taken = !flag_c;
      CondHi:  taken = flag_l;
      CondLs:  taken = !flag_l;
      CondGt:  taken = flag_n;
      CondLe:  taken = !flag_n;
      CondFs:  taken = flag_f;
      CondFc:  taken = !flag_f;
      CondLo:  taken = !flag_l && !flag_z;
      CondHs:  taken = flag_l || flag_z;
      CondLt:  taken = !flag_n && !flag_z;
      CondGe:  taken = flag_n || flag_z;
      CondUc:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multicycle controller FSM with req/rdy memory handshake, bounded WAIT and TRAP.
// Define CTRL_PERF_CNT_EN to add the cycle_cnt / retired_cnt performance counters.
module mc_ctrl_hs
  import ctrl_defs::*;
#(
  parameter int unsigned WAIT_CYCLES = 16777216,
  parameter int unsigned WAIT_W      = 25,
  parameter int unsigned PSR_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic [3:0]       op_ext,
  input  logic [3:0]       branch_cond,
  input  logic [PSR_W-1:0] PSR,
  input  logic             mem_rdy,
  input  logic             wake,
  output logic             mem_req,
  output logic [1:0]       WD_S,
  output logic [1:0]       ALUA_S,
  output logic [1:0]       ALUB_S,
  output logic [1:0]       MEM_S,
  output logic [1:0]       MEM_DATA_S,
  output logic             PC_S,
  output logic             PC_EN,
  output logic             REG_WR_EN,
  output logic             INSTR_EN,
  output logic             ALU_OUT_EN,
  output logic             MEM_REG_EN,
  output logic             MEM_WR_S,
  output logic             SE_SIGN,
  output logic             PSR_EN,
  output logic             halted
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]      cycle_cnt,
  output logic [31:0]      retired_cnt
`endif
);

  logic [StateW-1:0] state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              taken;
  logic              wait_done;
  ctrl_out_t         ctl;

  cond_eval #(
    .PSR_W(PSR_W)
  ) u_cond_eval (
    .branch_cond(branch_cond),
    .PSR        (PSR),
    .taken      (taken)
  );

  assign wait_done  = wake || (wait_cnt_q == WAIT_W'(WAIT_CYCLES - 1));
  // Counter only runs in WAIT and stops at the exit value, so it never wraps.
  assign wait_cnt_d = (state_q == StWait && !wait_done) ? wait_cnt_q + 1'b1 : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: if (mem_rdy) state_d = StDecode;
      StDecode: begin
        case (op)
          OpRtype: state_d = StREx;
          OpShift: state_d = (op_ext == ExtLsh) ? StREx : StIEx;
          OpBcond: state_d = taken ? StCalcDisp : StPcUp;
          OpSpecial: begin
            case (op_ext)
              ExtStor:  state_d = StStMem;
              ExtLoad:  state_d = StLdMem;
              ExtJcond: state_d = taken ? StJump : StPcUp;
              ExtJal:   state_d = StCalcRlink;
              default:  state_d = StTrap;
            endcase
          end
          default: state_d = StIEx;
        endcase
      end
      StREx: begin
        if (op_ext == ExtCmp)       state_d = StPcUp;
        else if (op_ext == ExtWait) state_d = StWait;
        else                        state_d = StWrite;
      end
      StIEx: begin
        if (op == OpCmpi)     state_d = StPcUp;
        else if (op == OpSti) state_d = StStiMem;
        else                  state_d = StWrite;
      end
      StWrite:     state_d = StPcUp;
      StLdMem:     if (mem_rdy) state_d = StLdWb;
      StLdWb:      state_d = StPcUp;
      StStMem:     if (mem_rdy) state_d = StPcUp;
      StStiMem:    if (mem_rdy) state_d = StPcUp;
      StCalcDisp:  state_d = StFetch;
      StJump:      state_d = StFetch;
      StCalcRlink: state_d = StWrRlink;
      StWrRlink:   state_d = StFetch;
      StPcUp:      state_d = StFetch;
      StWait:      if (wait_done) state_d = StPcUp;
      StTrap:      state_d = StTrap;
      default:     state_d = StTrap;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StFetch;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Moore control word; only INSTR_EN and MEM_REG_EN look at mem_rdy directly.
  always_comb begin
    ctl = ctrl_default();
    case (state_q)
      StFetch: begin
        ctl.mem_req  = 1'b1;
        ctl.mem_s    = MemAddrPc;
        ctl.instr_en = mem_rdy;
      end
      StREx: begin
        ctl.alu_out_en = 1'b1;
        ctl.psr_en     = 1'b1;
      end
      StIEx: begin
        ctl.alua_s     = AluAImm;
        ctl.alu_out_en = 1'b1;
        ctl.psr_en     = 1'b1;
        ctl.se_sign    = !(op inside {OpAndi, OpOri, OpXori});
      end
      StWrite: begin
        ctl.wd_s      = WdAlu;
        ctl.reg_wr_en = 1'b1;
      end
      StLdMem: begin
        ctl.mem_req    = 1'b1;
        ctl.wd_s       = WdMem;
        ctl.mem_reg_en = mem_rdy;
      end
      StLdWb: begin
        ctl.wd_s      = WdMem;
        ctl.reg_wr_en = 1'b1;
      end
      StStMem: begin
        ctl.mem_req    = 1'b1;
        ctl.mem_data_s = MemDataReg;
        ctl.mem_wr_s   = 1'b1;
      end
      StStiMem: begin
        ctl.mem_req    = 1'b1;
        ctl.mem_s      = MemAddrImm;
        ctl.mem_data_s = MemDataImm;
        ctl.mem_wr_s   = 1'b1;
      end
      StCalcDisp: begin
        ctl.alua_s = AluAPc;
        ctl.alub_s = AluBDisp;
        ctl.pc_s   = 1'b1;
        ctl.pc_en  = 1'b1;
      end
      StJump: ctl.pc_en = 1'b1;
      StCalcRlink: begin
        ctl.alua_s     = AluAPc;
        ctl.alub_s     = AluBOne;
        ctl.alu_out_en = 1'b1;
      end
      StWrRlink: begin
        ctl.wd_s      = WdAlu;
        ctl.reg_wr_en = 1'b1;
        ctl.pc_en     = 1'b1;
      end
      StPcUp: begin
        ctl.alua_s = AluAPc;
        ctl.alub_s = AluBOne;
        ctl.pc_s   = 1'b1;
        ctl.pc_en  = 1'b1;
      end
      StTrap:  ctl.halted = 1'b1;
      default: ctl = ctrl_default();
    endcase
  end

  assign mem_req    = ctl.mem_req;
  assign WD_S       = ctl.wd_s;
  assign ALUA_S     = ctl.alua_s;
  assign ALUB_S     = ctl.alub_s;
  assign MEM_S      = ctl.mem_s;
  assign MEM_DATA_S = ctl.mem_data_s;
  assign PC_S       = ctl.pc_s;
  assign PC_EN      = ctl.pc_en;
  assign REG_WR_EN  = ctl.reg_wr_en;
  assign INSTR_EN   = ctl.instr_en;
  assign ALU_OUT_EN = ctl.alu_out_en;
  assign MEM_REG_EN = ctl.mem_reg_en;
  assign MEM_WR_S   = ctl.mem_wr_s;
  assign SE_SIGN    = ctl.se_sign;
  assign PSR_EN     = ctl.psr_en;
  assign halted     = ctl.halted;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, retired_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
    end else begin
      if (state_q != StTrap) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (state_q != StFetch && state_d == StFetch) retired_cnt_q <= retired_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Self-checking bench for mc_ctrl_hs: instructions are expanded into expected
// per-cycle control words from the instruction-level behaviour, then replayed.
module tb_mc_ctrl_hs;

  localparam int unsigned WC = 8;

  typedef struct packed {
    logic       mem_req;
    logic [1:0] wd_s;
    logic [1:0] alua_s;
    logic [1:0] alub_s;
    logic [1:0] mem_s;
    logic [1:0] mem_data_s;
    logic       pc_s;
    logic       pc_en;
    logic       reg_wr_en;
    logic       instr_en;
    logic       alu_out_en;
    logic       mem_reg_en;
    logic       mem_wr_s;
    logic       se_sign;
    logic       psr_en;
    logic       halted;
  } outs_t;

  typedef struct {
    string      name;
    outs_t      exp;
    logic       rdy;
    logic       wk;
    logic [3:0] op;
    logic [3:0] ext;
    logic [3:0] cond;
    logic [4:0] psr;
  } phase_t;

  logic       clk, reset, mem_rdy, wake;
  logic [3:0] op, op_ext, branch_cond;
  logic [4:0] PSR;
  logic       mem_req, PC_S, PC_EN, REG_WR_EN, INSTR_EN, ALU_OUT_EN, MEM_REG_EN;
  logic       MEM_WR_S, SE_SIGN, PSR_EN, halted;
  logic [1:0] WD_S, ALUA_S, ALUB_S, MEM_S, MEM_DATA_S;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, retired_cnt;
`endif

  outs_t      act;
  int         errors = 0;
  int         checks = 0;
  phase_t     ph_q[$];
  logic [3:0] cur_op, cur_ext, cur_cond;
  logic [4:0] cur_psr;

  mc_ctrl_hs #(
    .WAIT_CYCLES(WC),
    .WAIT_W     (4),
    .PSR_W      (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .op_ext     (op_ext),
    .branch_cond(branch_cond),
    .PSR        (PSR),
    .mem_rdy    (mem_rdy),
    .wake       (wake),
    .mem_req    (mem_req),
    .WD_S       (WD_S),
    .ALUA_S     (ALUA_S),
    .ALUB_S     (ALUB_S),
    .MEM_S      (MEM_S),
    .MEM_DATA_S (MEM_DATA_S),
    .PC_S       (PC_S),
    .PC_EN      (PC_EN),
    .REG_WR_EN  (REG_WR_EN),
    .INSTR_EN   (INSTR_EN),
    .ALU_OUT_EN (ALU_OUT_EN),
    .MEM_REG_EN (MEM_REG_EN),
    .MEM_WR_S   (MEM_WR_S),
    .SE_SIGN    (SE_SIGN),
    .PSR_EN     (PSR_EN),
    .halted     (halted)
`ifdef CTRL_PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .retired_cnt(retired_cnt)
`endif
  );

  assign act = {mem_req, WD_S, ALUA_S, ALUB_S, MEM_S, MEM_DATA_S, PC_S, PC_EN, REG_WR_EN,
                INSTR_EN, ALU_OUT_EN, MEM_REG_EN, MEM_WR_S, SE_SIGN, PSR_EN, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic outs_t o_def();
    outs_t o;
    o = '0;
    o.se_sign = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_fetch(logic rdy);
    outs_t o;
    o = o_def();
    o.mem_req = 1'b1;
    o.mem_s = 2'b01;
    o.instr_en = rdy;
    return o;
  endfunction

  function automatic outs_t o_pcup();
    outs_t o;
    o = o_def();
    o.alua_s = 2'b01;
    o.alub_s = 2'b10;
    o.pc_s = 1'b1;
    o.pc_en = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_write();
    outs_t o;
    o = o_def();
    o.wd_s = 2'b11;
    o.reg_wr_en = 1'b1;
    return o;
  endfunction

  // Flags: PSR = {N,Z,F,L,C}. Codes come in complementary pairs; bit 0 inverts.
  function automatic logic taken_ref(logic [3:0] c, logic [4:0] p);
    logic [7:0] pred;
    logic [2:0] pair;
    pred = {1'b1, !p[4] && !p[3], !p[1] && !p[3], p[2], p[4], p[1], p[0], p[3]};
    pair = c[3:1];
    return pred[pair] ^ c[0];
  endfunction

  function automatic void push(string n, outs_t e, logic rdy, logic wk);
    phase_t p;
    p.name = n;
    p.exp = e;
    p.rdy = rdy;
    p.wk = wk;
    p.op = cur_op;
    p.ext = cur_ext;
    p.cond = cur_cond;
    p.psr = cur_psr;
    ph_q.push_back(p);
  endfunction

  function automatic void add_mem(string n, outs_t o_stall, outs_t o_done, int stalls);
    for (int i = 0; i < stalls; i++) push({n, "_stall"}, o_stall, 1'b0, rbit());
    push(n, o_done, 1'b1, rbit());
  endfunction

  // Expand one instruction into the control words expected on each cycle.
  function automatic void add_instr(logic [3:0] op_v, logic [3:0] ext_v, logic [3:0] cond_v,
                                    logic [4:0] psr_v, int f_stall, int m_stall, int wake_at,
                                    int trap_len);
    outs_t o, o2;
    int    n;
    cur_op = op_v;
    cur_ext = ext_v;
    cur_cond = cond_v;
    cur_psr = psr_v;
    add_mem("fetch", o_fetch(1'b0), o_fetch(1'b1), f_stall);
    push("decode", o_def(), rbit(), rbit());
    if (op_v == 4'b0000 || (op_v == 4'b1000 && ext_v == 4'b0100)) begin
      o = o_def();
      o.alu_out_en = 1'b1;
      o.psr_en = 1'b1;
      push("r_ex", o, rbit(), rbit());
      if (ext_v == 4'b0000) begin
        n = (wake_at == 0 || wake_at > int'(WC)) ? int'(WC) : wake_at;
        for (int k = 1; k <= n; k++) push("wait", o_def(), rbit(), k == wake_at);
      end else if (ext_v != 4'b1011) begin
        push("write", o_write(), rbit(), rbit());
      end
      push("pc_up", o_pcup(), rbit(), rbit());
    end else if (op_v == 4'b1100) begin
      if (taken_ref(cond_v, psr_v)) begin
        o = o_def();
        o.alua_s = 2'b01;
        o.alub_s = 2'b01;
        o.pc_s = 1'b1;
        o.pc_en = 1'b1;
        push("calc_disp", o, rbit(), rbit());
      end else begin
        push("pc_up", o_pcup(), rbit(), rbit());
      end
    end else if (op_v == 4'b0100) begin
      case (ext_v)
        4'b0000: begin
          o = o_def();
          o.mem_req = 1'b1;
          o.wd_s = 2'b10;
          o2 = o;
          o2.mem_reg_en = 1'b1;
          add_mem("ld_mem", o, o2, m_stall);
          o = o_def();
          o.wd_s = 2'b10;
          o.reg_wr_en = 1'b1;
          push("ld_wb", o, rbit(), rbit());
          push("pc_up", o_pcup(), rbit(), rbit());
        end
        4'b0100: begin
          o = o_def();
          o.mem_req = 1'b1;
          o.mem_wr_s = 1'b1;
          add_mem("st_mem", o, o, m_stall);
          push("pc_up", o_pcup(), rbit(), rbit());
        end
        4'b1100: begin
          if (taken_ref(cond_v, psr_v)) begin
            o = o_def();
            o.pc_en = 1'b1;
            push("jump", o, rbit(), rbit());
          end else begin
            push("pc_up", o_pcup(), rbit(), rbit());
          end
        end
        4'b1000: begin
          o = o_def();
          o.alua_s = 2'b01;
          o.alub_s = 2'b10;
          o.alu_out_en = 1'b1;
          push("calc_rlink", o, rbit(), rbit());
          o = o_write();
          o.pc_en = 1'b1;
          push("wr_rlink", o, rbit(), rbit());
        end
        default: begin
          o = o_def();
          o.halted = 1'b1;
          for (int i = 0; i < trap_len; i++) push("trap", o, rbit(), rbit());
        end
      endcase
    end else begin
      o = o_def();
      o.alua_s = 2'b10;
      o.alu_out_en = 1'b1;
      o.psr_en = 1'b1;
      o.se_sign = !(op_v inside {4'd1, 4'd2, 4'd3});
      push("i_ex", o, rbit(), rbit());
      if (op_v == 4'b0111) begin
        o = o_def();
        o.mem_req = 1'b1;
        o.mem_s = 2'b10;
        o.mem_data_s = 2'b01;
        o.mem_wr_s = 1'b1;
        add_mem("sti_mem", o, o, m_stall);
      end else if (op_v != 4'b1011) begin
        push("write", o_write(), rbit(), rbit());
      end
      push("pc_up", o_pcup(), rbit(), rbit());
    end
  endfunction

  task automatic drive(input phase_t p);
    op = p.op;
    op_ext = p.ext;
    branch_cond = p.cond;
    PSR = p.psr;
    mem_rdy = p.rdy;
    wake = p.wk;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mem_rdy = rbit();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    phase_t p;
    reset = 1'b0;
    mem_rdy = 1'b1;
    wake = 1'b0;
    op = '0;
    op_ext = '0;
    branch_cond = '0;
    PSR = '0;
    step();
    reset = 1'b1;
    mem_rdy = 1'b0;
    #2;
    checks++;
    if (act !== o_fetch(1'b0)) begin
      errors++;
      $display("FAIL reset_fetch: got %h want %h", act, o_fetch(1'b0));
    end
`ifdef CTRL_PERF_CNT_EN
    checks++;
    if (cycle_cnt !== 32'd0 || retired_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", cycle_cnt, retired_cnt);
    end
`endif
    step();
    p = '{name: "reset_fetch_hold", exp: o_fetch(1'b1), rdy: 1'b1, wk: 1'b0,
          op: 4'd0, ext: 4'd0, cond: 4'd0, psr: 5'd0};
    drive(p);
    checks++;
    if (act !== p.exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", p.name, act, p.exp);
    end
    do_reset();
  endtask

  task automatic test_alu();
    phase_t p;
    do_reset();
    add_instr(4'b0000, 4'b0101, 4'd0, 5'd0, 0, 0, 0, 0);
    while (ph_q.size() > 0) begin
      p = ph_q.pop_front();
      drive(p);
      checks++;
      if (act !== p.exp) begin
        errors++;
        $display("FAIL alu_%s: got %h want %h", p.name, act, p.exp);
      end
      step();
    end
`ifdef CTRL_PERF_CNT_EN
    checks++;
    if (cycle_cnt !== 32'd5 || retired_cnt !== 32'd1) begin
      errors++;
      $display("FAIL alu_counters: got %0d/%0d want 5/1", cycle_cnt, retired_cnt);
    end
`endif
  endtask

  task automatic test_load();
    phase_t p;
    add_instr(4'b0100, 4'b0000, 4'd0, 5'd0, 1, 3, 0, 0);
    while (ph_q.size() > 0) begin
      p = ph_q.pop_front();
      drive(p);
      checks++;
      if (act !== p.exp) begin
        errors++;
        $display("FAIL load_%s: got %h want %h", p.name, act, p.exp);
      end
      step();
    end
  endtask

  task automatic test_wait();
    phase_t p;
    add_instr(4'b0000, 4'b0000, 4'd0, 5'd0, 0, 0, 0, 0);
    add_instr(4'b0000, 4'b0000, 4'd0, 5'd0, 0, 0, 3, 0);
    add_instr(4'b0000, 4'b0000, 4'd0, 5'd0, 0, 0, 1, 0);
    while (ph_q.size() > 0) begin
      p = ph_q.pop_front();
      drive(p);
      checks++;
      if (act !== p.exp) begin
        errors++;
        $display("FAIL wait_%s: got %h want %h", p.name, act, p.exp);
      end
      step();
    end
  endtask

  task automatic test_branch();
    phase_t p;
    add_instr(4'b1100, 4'b0000, 4'b0000, 5'b01000, 0, 0, 0, 0);
    add_instr(4'b1100, 4'b0000, 4'b0000, 5'b00000, 0, 0, 0, 0);
    add_instr(4'b0100, 4'b1100, 4'b1110, 5'b00000, 0, 0, 0, 0);
    add_instr(4'b0100, 4'b1100, 4'b1111, 5'b11111, 0, 0, 0, 0);
    add_instr(4'b0100, 4'b1000, 4'b0000, 5'b00000, 0, 0, 0, 0);
    while (ph_q.size() > 0) begin
      p = ph_q.pop_front();
      drive(p);
      checks++;
      if (act !== p.exp) begin
        errors++;
        $display("FAIL branch_%s: got %h want %h", p.name, act, p.exp);
      end
      step();
    end
  endtask

  task automatic test_trap();
    phase_t p;
    do_reset();
    add_instr(4'b0100, 4'b0011, 4'd0, 5'd0, 0, 0, 0, 22);
    while (ph_q.size() > 0) begin
      p = ph_q.pop_front();
      drive(p);
      checks++;
      if (act !== p.exp) begin
        errors++;
        $display("FAIL trap_%s: got %h want %h", p.name, act, p.exp);
      end
      step();
    end
`ifdef CTRL_PERF_CNT_EN
    checks++;
    if (cycle_cnt !== 32'd2 || retired_cnt !== 32'd0) begin
      errors++;
      $display("FAIL trap_counters: got %0d/%0d want 2/0", cycle_cnt, retired_cnt);
    end
`endif
    do_reset();
    mem_rdy = 1'b0;
    #2;
    checks++;
    if (act !== o_fetch(1'b0)) begin
      errors++;
      $display("FAIL trap_exit_fetch: got %h want %h", act, o_fetch(1'b0));
    end
    step();
  endtask

  task automatic test_reset_mid_store();
    phase_t p;
    add_instr(4'b0100, 4'b0100, 4'd0, 5'd0, 0, 5, 0, 0);
    for (int i = 0; i < 4; i++) begin
      p = ph_q.pop_front();
      drive(p);
      checks++;
      if (act !== p.exp) begin
        errors++;
        $display("FAIL mid_store_%s: got %h want %h", p.name, act, p.exp);
      end
      step();
    end
    ph_q.delete();
    do_reset();
    mem_rdy = 1'b0;
    #2;
    checks++;
    if (act !== o_fetch(1'b0)) begin
      errors++;
      $display("FAIL reset_mid_store: got %h want %h", act, o_fetch(1'b0));
    end
`ifdef CTRL_PERF_CNT_EN
    checks++;
    if (cycle_cnt !== 32'd0 || retired_cnt !== 32'd0) begin
      errors++;
      $display("FAIL mid_store_counters: got %0d/%0d want 0/0", cycle_cnt, retired_cnt);
    end
`endif
    step();
  endtask

  task automatic test_random();
    phase_t     p;
    logic [3:0] r_op, r_ext;
    for (int n = 0; n < 60; n++) begin
      r_op = 4'($urandom_range(0, 15));
      r_ext = 4'($urandom_range(0, 15));
      if (r_op == 4'b0100) r_ext = {2'($urandom_range(0, 3)), 2'b00};
      if (r_op == 4'b0000 && $urandom_range(0, 3) == 0) r_ext = 4'b0000;
      add_instr(r_op, r_ext, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, WC + 1), 0);
      while (ph_q.size() > 0) begin
        p = ph_q.pop_front();
        drive(p);
        checks++;
        if (act !== p.exp) begin
          errors++;
          $display("FAIL rand%0d_%s op=%h ext=%h: got %h want %h", n, p.name, p.op, p.ext,
                   act, p.exp);
        end
        step();
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_wait();
    test_branch();
    test_random();
    test_trap();
    test_reset_mid_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
